// File: rtl/clk_gen.sv
// clk_gen: divides clkin down to a 50%-duty square wave on clkout.
// clkout toggles once every COUNT_LIMIT enabled clkin edges, so one full
// period is 2*COUNT_LIMIT enabled cycles. clken low freezes the divider.
// clkout comes straight from a flop, so no input has a combinational path to it.
module clk_gen #(
  parameter int unsigned SYS_FREQ    = 50000000,
  parameter int unsigned CLK_FREQ    = 1000,
  parameter int unsigned COUNT_LIMIT = ((SYS_FREQ / 2 / CLK_FREQ) < 1) ? 1
                                       : (SYS_FREQ / 2 / CLK_FREQ)
) (
  input  logic clkin,
  input  logic rst,
  input  logic clken,
  output logic clkout
);

  // A direct override of 0 is treated like a computed value below 1.
  localparam int unsigned Limit   = (COUNT_LIMIT < 1) ? 1 : COUNT_LIMIT;
  localparam logic [31:0] LastCnt = 32'(Limit - 1);

  logic [31:0] cnt_q, cnt_d;
  logic        clkout_q, clkout_d;

  // Next state: wrap and toggle at the end of a half-period, hold while disabled.
  always_comb begin
    cnt_d    = cnt_q;
    clkout_d = clkout_q;
    if (clken) begin
      if (cnt_q == LastCnt) begin
        cnt_d    = '0;
        clkout_d = ~clkout_q;
      end else begin
        cnt_d    = cnt_q + 32'd1;
      end
    end
  end

  // State registers; reset clears the partial count and the output at once.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      clkout_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clkout_q <= clkout_d;
    end
  end

  assign clkout = clkout_q;

endmodule

// File: tb/tb_clk_gen.sv
// Bench for clk_gen: table-driven blocks of stimulus on a COUNT_LIMIT=10
// instance, plus hand-written sequences for async reset, COUNT_LIMIT=1 and
// the default-parameter resolution. Expected values go through a queue.
module tb_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, out_a;
  logic rst_b, en_b, out_b;
  logic rst_c, en_c, out_c;

  clk_gen #(.SYS_FREQ(80), .CLK_FREQ(4)) u10 (
    .clkin (clk),
    .rst   (rst_a),
    .clken (en_a),
    .clkout(out_a)
  );

  clk_gen #(.COUNT_LIMIT(1)) u1 (
    .clkin (clk),
    .rst   (rst_b),
    .clken (en_b),
    .clkout(out_b)
  );

  clk_gen #(.CLK_FREQ(4)) ud (
    .clkin (clk),
    .rst   (rst_c),
    .clken (en_c),
    .clkout(out_c)
  );

  typedef struct {
    logic        rst;
    logic        en;
    int          reps;
    logic        exp_out;
    int unsigned exp_cnt;
    string       name;
  } vec_t;

  typedef struct {
    logic        exp_out;
    int unsigned exp_cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the given instance outputs.
  task automatic pop_check(input logic act_out, input int unsigned act_cnt);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_clkout"}, longint'(act_out), longint'(e.exp_out));
      chk({e.name, "_cnt"}, longint'(act_cnt), longint'(e.exp_cnt));
    end
  endtask

  // Apply one table entry to the COUNT_LIMIT=10 instance, then check it.
  task automatic run_vec(input vec_t v);
    exp_t e;
    e.exp_out = v.exp_out;
    e.exp_cnt = v.exp_cnt;
    e.name    = v.name;
    sb.push_back(e);
    for (int i = 0; i < v.reps; i++) begin
      @(negedge clk);
      rst_a = v.rst;
      en_a  = v.en;
      @(posedge clk);
    end
    #1;
    pop_check(out_a, u10.cnt_q);
  endtask

  vec_t vecs[$];

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    rst_c = 1'b1; en_c = 1'b0;

    // Plain division: toggles after enabled edges 10, 20, 30.
    vecs.push_back('{1'b1, 1'b1, 2,  1'b0, 0, "reset"});
    vecs.push_back('{1'b0, 1'b1, 9,  1'b0, 9, "pre_rise"});
    vecs.push_back('{1'b0, 1'b1, 1,  1'b1, 0, "rise_e10"});
    vecs.push_back('{1'b0, 1'b1, 9,  1'b1, 9, "high_e19"});
    vecs.push_back('{1'b0, 1'b1, 1,  1'b0, 0, "fall_e20"});
    vecs.push_back('{1'b0, 1'b1, 9,  1'b0, 9, "low_e29"});
    vecs.push_back('{1'b0, 1'b1, 1,  1'b1, 0, "rise_e30"});
    // Enable gap of 5 cycles after 4 enabled edges: toggle at clkin edge 15.
    vecs.push_back('{1'b1, 1'b1, 1,  1'b0, 0, "reset2"});
    vecs.push_back('{1'b0, 1'b1, 4,  1'b0, 4, "gap_pre"});
    vecs.push_back('{1'b0, 1'b0, 5,  1'b0, 4, "gap_hold"});
    vecs.push_back('{1'b0, 1'b1, 5,  1'b0, 9, "gap_post"});
    vecs.push_back('{1'b0, 1'b1, 1,  1'b1, 0, "gap_rise"});
    // Disabled from reset for 1000 cycles: nothing moves.
    vecs.push_back('{1'b1, 1'b0, 1,  1'b0, 0, "reset3"});
    vecs.push_back('{1'b0, 1'b0, 1000, 1'b0, 0, "idle_1000"});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Async reset mid-cycle with clkout=1 and cnt=7.
    run_vec('{1'b1, 1'b1, 1,  1'b0, 0, "reset4"});
    run_vec('{1'b0, 1'b1, 17, 1'b1, 7, "pre_async"});
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_clkout", longint'(out_a), 0);
    chk("async_cnt", longint'(u10.cnt_q), 0);
    run_vec('{1'b1, 1'b1, 2,  1'b0, 0, "async_hold"});
    run_vec('{1'b0, 1'b1, 9,  1'b0, 9, "post_async_e9"});
    run_vec('{1'b0, 1'b1, 1,  1'b1, 0, "post_async_e10"});

    // COUNT_LIMIT=1: clkout alternates every enabled edge.
    @(negedge clk);
    rst_b = 1'b0;
    en_b  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      exp_t e;
      e.exp_out = (i % 2 == 1);
      e.exp_cnt = 0;
      e.name    = "div2";
      sb.push_back(e);
      @(posedge clk);
      #1;
      pop_check(out_b, u1.cnt_q);
    end

    // Default SYS_FREQ with CLK_FREQ=4 resolves to 6,250,000.
    chk("default_limit", longint'(ud.Limit), 64'd6250000);
    @(negedge clk);
    rst_c = 1'b0;
    en_c  = 1'b1;
    begin
      exp_t e;
      e.exp_out = 1'b0;
      e.exp_cnt = 100;
      e.name    = "default_run";
      sb.push_back(e);
    end
    repeat (100) @(posedge clk);
    #1;
    pop_check(out_c, ud.cnt_q);

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
